demux_sched_8: RTL and testbench

DEMUX_SCHED_8 -- requirements
Module: demux_sched_8

---
 rtl/demux_sched_pkg.sv | 10 +
 rtl/demux_sched_8_rr_pick8.sv | 25 ++
 rtl/demux_sched_8.sv | 98 +++++++++
 tb/tb_demux_sched_8.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared constants and FSM state type for the 8-way demux scheduler.
package demux_sched_pkg;
    localparam int N_OUT = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/demux_sched_8_rr_pick8.sv
// Cyclic first-set search over an 8-bit mask starting at a 3-bit pointer.
module rr_pick8
    import demux_sched_pkg::*;
(
    input  logic [N_OUT-1:0] i_mask,
    input  logic [SEL_W-1:0] i_start,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_found
);
    logic [SEL_W-1:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_pos   = '0;
        for (int k = N_OUT - 1; k >= 0; k--) begin
            w_pos = i_start + SEL_W'(k);
            if (i_mask[w_pos]) begin
                o_idx   = w_pos;
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_sched_8.sv
// One-beat-deep 1-to-8 demux with addressed or round-robin destination choice.
module demux_sched_8
    import demux_sched_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [7:0]       en_mask,
    input  logic             in_valid,
    input  logic             in_data,
    input  logic [2:0]       in_dest,
    output logic             in_ready,
    output logic [7:0]       out_valid,
    output logic [7:0]       out_data,
    input  logic [7:0]       out_ready,
    output logic [2:0]       sel,
    output logic             drop_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);
    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [N_OUT-1:0]   r_out_valid;
    logic [N_OUT-1:0]   r_out_data;
    logic               r_drop;
    logic               r_busy;
    logic [CNT_W-1:0]   r_xfer;

    logic [SEL_W-1:0]   w_rr_idx;
    logic               w_rr_found;
    logic [SEL_W-1:0]   w_target;
    logic               w_masked;
    logic [N_OUT-1:0]   w_onehot;

    rr_pick8 u_pick (
        .i_mask  (en_mask),
        .i_start (r_rr_ptr),
        .o_idx   (w_rr_idx),
        .o_found (w_rr_found)
    );

    // Ready is the only combinational output; gated by rst_n so it is low in reset.
    assign in_ready = rst_n && (r_state == IDLE) && (!mode || (en_mask != '0));
    assign w_target = mode ? w_rr_idx : in_dest;
    assign w_masked = mode ? !w_rr_found : !en_mask[in_dest];
    assign w_onehot = N_OUT'(1) << w_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= '0;
            r_out_data  <= '0;
            r_drop      <= 1'b0;
            r_busy      <= 1'b0;
            r_xfer      <= '0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (w_masked) begin
                            r_drop <= 1'b1;
                        end else begin
                            r_sel       <= w_target;
                            r_out_valid <= w_onehot;
                            r_out_data  <= in_data ? w_onehot : '0;
                            r_busy      <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready[r_sel]) begin
                        r_xfer      <= r_xfer + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_rr_ptr    <= r_sel + SEL_W'(1);
                        r_out_valid <= '0;
                        r_out_data  <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign sel        = r_sel;
    assign drop_pulse = r_drop;
    assign busy       = r_busy;
    assign xfer_cnt   = r_xfer;
endmodule

// File: tb/tb_demux_sched_8.sv
// Directed bench for demux_sched_8 with a behavioural reference checked every cycle.
module tb_demux_sched_8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode = 1'b0;
    logic [7:0]       en_mask = 8'hFF;
    logic             in_valid = 1'b0;
    logic             in_data = 1'b0;
    logic [2:0]       in_dest = 3'd0;
    logic             in_ready;
    logic [7:0]       out_valid;
    logic [7:0]       out_data;
    logic [7:0]       out_ready = 8'hFF;
    logic [2:0]       sel;
    logic             drop_pulse;
    logic             busy;
    logic [CNT_W-1:0] xfer_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    demux_sched_8 #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .en_mask    (en_mask),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
        .drop_pulse (drop_pulse),
        .busy       (busy),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: one held beat at most, described by plain integers.
    int m_busy, m_sel, m_data, m_cnt, m_ptr, m_drop;

    function automatic int rr_first(input logic [7:0] mask, input int ptr);
        for (int k = 0; k < 8; k++)
            if (mask[(ptr + k) % 8]) return (ptr + k) % 8;
        return -1;
    endfunction

    function automatic bit m_ready();
        return rst_n && (m_busy == 0) && (mode == 1'b0 || en_mask != 8'h00);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_sel <= 0; m_data <= 0; m_cnt <= 0; m_ptr <= 0; m_drop <= 0;
        end else begin
            m_drop <= 0;
            if (m_busy != 0) begin
                if (out_ready[m_sel]) begin
                    m_busy <= 0;
                    m_data <= 0;
                    m_cnt  <= (m_cnt + 1) % (1 << CNT_W);
                    m_ptr  <= (m_sel + 1) % 8;
                end
            end else if (in_valid && m_ready()) begin
                if (mode == 1'b0 && !en_mask[in_dest]) begin
                    m_drop <= 1;
                end else begin
                    m_busy <= 1;
                    m_sel  <= (mode == 1'b0) ? int'(in_dest) : rr_first(en_mask, m_ptr);
                    m_data <= int'(in_data);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",   32'(in_ready),   32'(m_ready()));
        chk("out_valid",  32'(out_valid),  (m_busy != 0) ? (32'd1 << m_sel) : 32'd0);
        chk("out_data",   32'(out_data),   (m_busy != 0) ? (32'(m_data) << m_sel) : 32'd0);
        chk("sel",        32'(sel),        32'(m_sel));
        chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("xfer_cnt",   32'(xfer_cnt),   32'(m_cnt));
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] seen [$];
    logic [2:0] want [4];

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_xfer", 32'(xfer_cnt), 0);
        step();
        rst_n = 1'b1;

        // Addressed beat to 5
        mode = 0; en_mask = 8'hFF; in_dest = 3'd5; in_data = 1; in_valid = 1; out_ready = 8'hFF;
        @(negedge clk);
        chk("a_in_ready", 32'(in_ready), 1);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("a_out_valid", 32'(out_valid), 32'h20);
        chk("a_out_data", 32'(out_data), 32'h20);
        chk("a_sel", 32'(sel), 5);
        step();
        @(negedge clk);
        chk("a_busy", 32'(busy), 0);
        chk("a_xfer", 32'(xfer_cnt), 1);
        chk("a_sel_kept", 32'(sel), 5);

        // Drop to masked destination 2
        step();
        en_mask = 8'hFB; in_dest = 3'd2; in_valid = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        chk("d_drop", 32'(drop_pulse), 1);
        chk("d_out_valid", 32'(out_valid), 0);
        chk("d_in_ready", 32'(in_ready), 1);
        chk("d_xfer", 32'(xfer_cnt), 1);
        step();
        @(negedge clk);
        chk("d_drop_end", 32'(drop_pulse), 0);

        // Round-robin over 91h from a fresh pointer
        step();
        rst_n = 0;
        #1 rst_n = 1;
        mode = 1; en_mask = 8'h91; out_ready = 8'hFF; in_data = 0; in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 6) in_valid = 0;
            @(negedge clk);
            if (busy) seen.push_back(sel);
        end
        want[0] = 3'd0; want[1] = 3'd4; want[2] = 3'd7; want[3] = 3'd0;
        chk("rr_count", 32'(seen.size()), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("rr_dest", 32'(seen[i]), 32'(want[i]));
        chk("rr_xfer", 32'(xfer_cnt), 4);

        // Stall on sel 3, inputs changed during the hold
        step();
        mode = 0; en_mask = 8'hFF; in_dest = 3'd3; in_data = 1; out_ready = 8'hF7; in_valid = 1;
        step();
        in_valid = 0; mode = 1; en_mask = 8'h00; in_dest = 3'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("h_out_valid", 32'(out_valid), 32'h08);
            chk("h_in_ready", 32'(in_ready), 0);
            step();
        end
        out_ready = 8'h08;
        step();
        @(negedge clk);
        chk("h_busy", 32'(busy), 0);
        chk("h_xfer", 32'(xfer_cnt), 5);

        // Round-robin with nothing enabled, then only 6
        mode = 1; en_mask = 8'h00; in_valid = 1; out_ready = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("z_in_ready", 32'(in_ready), 0);
            step();
        end
        chk("z_busy", 32'(busy), 0);
        en_mask = 8'h40;
        step();
        in_valid = 0;
        @(negedge clk);
        chk("z_sel", 32'(sel), 6);
        chk("z_out_valid", 32'(out_valid), 32'h40);
        step();

        // Reset during hold
        mode = 0; en_mask = 8'hFF; in_dest = 3'd1; in_data = 1; out_ready = 8'h00; in_valid = 1;
        step();
        in_valid = 0;
        #1 rst_n = 0;
        #1;
        chk("r_out_valid", 32'(out_valid), 0);
        chk("r_out_data", 32'(out_data), 0);
        chk("r_sel", 32'(sel), 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_in_ready", 32'(in_ready), 0);
        chk("r_xfer", 32'(xfer_cnt), 0);
        chk("r_drop", 32'(drop_pulse), 0);
        step();
        in_dest = 3'd0; out_ready = 8'hFF; in_valid = 1;
        rst_n = 1;
        step();
        chk("r_first_accept", 32'(busy), 1);

        // 256 completions wrap the counter
        for (int i = 0; i < 510; i++) step();
        in_valid = 0;
        @(negedge clk);
        chk("w_xfer_255", 32'(xfer_cnt), 255);
        chk("w_busy", 32'(busy), 1);
        step();
        @(negedge clk);
        chk("w_xfer_wrap", 32'(xfer_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
